// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared FSM state type and default constants for the UART receiver
package uart_rx_pkg;

  // 50 MHz system clock, 38400 baud, 8N1 framing
  localparam int DEFAULT_CLKS_PER_BIT = 1302;
  localparam int DEFAULT_HALF_BIT     = 651;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - bit-period counter with half-bit and full-bit tick decodes
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = DEFAULT_HALF_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LP_HALF_LAST = W'(HALF_BIT - 1);
  localparam logic [W-1:0] LP_FULL_LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_count;

  // Free-running bit counter; clear holds it at zero and restarts it on state changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || (r_count == LP_FULL_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign half_tick = (r_count == LP_HALF_LAST);
  assign full_tick = (r_count == LP_FULL_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver: synchronizer, frame FSM, shift register and byte handshake
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = DEFAULT_HALF_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LP_LAST_BIT = IW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_d;
  rx_state_t            r_state;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 r_busy;

  logic                 w_half_tick;
  logic                 w_full_tick;
  logic                 w_clear;
  logic                 w_fall;

  // Two-flop synchronizer plus one delay flop for falling-edge detection; idle line is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  // A level held low never looks like an edge, so a break cannot start a frame
  assign w_fall = r_rx_d & ~r_rx_s;

  // Timer restart: held in IDLE and asserted on exactly the cycles the FSM leaves a state
  always_comb begin
    w_clear = 1'b1;
    case (r_state)
      ST_IDLE:  w_clear = 1'b1;
      ST_START: w_clear = w_half_tick;
      ST_DATA:  w_clear = w_full_tick && (r_bit_idx == LP_LAST_BIT);
      ST_STOP:  w_clear = w_full_tick;
      default:  w_clear = 1'b1;
    endcase
  end

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .HALF_BIT    (HALF_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .half_tick(w_half_tick),
    .full_tick(w_full_tick)
  );

  // Frame FSM with registered outputs; a good-frame load takes priority over an ack clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (r_valid && rx_ack) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_half_tick) begin
            if (!r_rx_s) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_full_tick) begin
            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == LP_LAST_BIT) begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (w_full_tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (r_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_ovr   <= r_valid && !rx_ack;
            end else begin
              r_ferr <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a frame-level reference model
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
  localparam int HB  = 8;
  localparam int DB  = 8;
  localparam int LAT = 2 + HB + (DB + 1) * CPB;
  localparam int FRAME_CYCLES = (DB + 2) * CPB;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       rx     = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HB),
    .DATA_BITS   (DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int e      = 0;

  // Expected events keyed by the rising-edge number after which they become visible
  logic [7:0] ev_good[int];
  bit         ev_ferr[int];
  bit         ev_bon[int];
  bit         ev_boff[int];

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_busy  = 1'b0;

  int   ferr_seen  = 0;
  int   ovr_seen   = 0;
  int   rise_e     = -1;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Reference model: frame outcomes land at fixed edges, handshake follows the ack/load rules
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
    end else begin
      e = e + 1;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (ev_good.exists(e)) begin
        m_ovr   = m_valid && !rx_ack;
        m_data  = ev_good[e];
        m_valid = 1'b1;
      end else if (m_valid && rx_ack) begin
        m_valid = 1'b0;
      end
      if (ev_ferr.exists(e)) m_ferr = 1'b1;
      if (ev_bon.exists(e))  m_busy = 1'b1;
      if (ev_boff.exists(e)) m_busy = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model, on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("rx_data",   int'(rx_data),   int'(m_data));
      chk("rx_valid",  int'(rx_valid),  int'(m_valid));
      chk("frame_err", int'(frame_err), int'(m_ferr));
      chk("overrun",   int'(overrun),   int'(m_ovr));
      chk("busy",      int'(busy),      int'(m_busy));
      if (frame_err) ferr_seen++;
      if (overrun)   ovr_seen++;
      if (rx_valid && !prev_valid) rise_e = e;
    end
    prev_valid = rx_valid;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"},   int'(rx_data),   0);
    chk({tag, "_rx_valid"},  int'(rx_valid),  0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    chk({tag, "_overrun"},   int'(overrun),   0);
    chk({tag, "_busy"},      int'(busy),      0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    rx    = 1'b1;
    ev_good.delete();
    ev_ferr.delete();
    ev_bon.delete();
    ev_boff.delete();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at);
    logic [9:0] fb;
    int k;
    fb = {stop, d, 1'b0};
    k  = e + 1;
    ev_bon[k + 2]    = 1'b1;
    ev_boff[k + LAT] = 1'b1;
    if (stop) ev_good[k + LAT] = d;
    else      ev_ferr[k + LAT] = 1'b1;
    for (int c = 0; c < FRAME_CYCLES; c++) begin
      if (c == abort_at) begin
        do_reset();
        return;
      end
      if ((c != 0) && (c % CPB == 0)) fb = fb >> 1;
      rx = fb[0];
      @(negedge clk);
    end
  endtask

  task automatic send_glitch(input int low_cycles);
    int k;
    k = e + 1;
    ev_bon[k + 2]       = 1'b1;
    ev_boff[k + 2 + HB] = 1'b1;
    rx = 1'b0;
    repeat (low_cycles) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  int e0;
  int o0;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Start-bit glitch is rejected
    send_glitch(4);
    repeat (20) @(negedge clk);
    chk("glitch_valid", int'(rx_valid), 0);
    chk("glitch_ferr_cnt", ferr_seen, 0);
    chk("glitch_busy", int'(busy), 0);

    // Bad stop bit, then line held low (break) must not start a frame
    send_frame(8'h3C, 1'b0, -1);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_cnt", ferr_seen, 1);
    chk("ferr_rx_data", int'(rx_data), 0);
    chk("ferr_rx_valid", int'(rx_valid), 0);

    // Good frame, held without ack, then acknowledged
    e0 = e;
    send_frame(8'hA5, 1'b1, -1);
    repeat (20) @(negedge clk);
    chk("a5_rx_data", int'(rx_data), 32'hA5);
    chk("a5_rx_valid", int'(rx_valid), 1);
    chk("a5_latency", rise_e, e0 + 1 + LAT);
    chk("a5_ovr_cnt", ovr_seen, 0);
    pulse_ack();
    chk("a5_ack_clear", int'(rx_valid), 0);
    pulse_ack();
    chk("idle_ack_ignored", int'(rx_valid), 0);
    repeat (5) @(negedge clk);

    // Back-to-back frames without ack overwrite and flag one overrun
    o0 = ovr_seen;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    repeat (20) @(negedge clk);
    chk("b2b_ovr_cnt", ovr_seen - o0, 1);
    chk("b2b_rx_data", int'(rx_data), 32'h22);
    chk("b2b_rx_valid", int'(rx_valid), 1);

    // Ack coinciding with the second load: no overrun
    pulse_ack();
    repeat (5) @(negedge clk);
    o0 = ovr_seen;
    send_frame(8'h11, 1'b1, -1);
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        repeat (LAT) @(negedge clk);
        pulse_ack();
      end
    join
    repeat (20) @(negedge clk);
    chk("coinc_ovr_cnt", ovr_seen - o0, 0);
    chk("coinc_rx_data", int'(rx_data), 32'h22);
    chk("coinc_rx_valid", int'(rx_valid), 1);

    // Reset during data bit 4, then a clean frame
    send_frame(8'h5A, 1'b1, CPB * 5);
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, -1);
    repeat (20) @(negedge clk);
    chk("post_reset_rx_data", int'(rx_data), 32'h5A);
    chk("post_reset_rx_valid", int'(rx_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1302: clock cycles per bit period (50 MHz / 38400).
REQ-002 Parameter HALF_BIT, default 651: cycles from start-bit edge to start-bit mid-point check.
REQ-003 Parameter DATA_BITS, default 8: data bits per frame; no parity.
REQ-004 Port clk  input  1  system clock; all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 Port rx_ack  input  1  consumer acknowledge of held byte.
REQ-008 Port rx_data  output  DATA_BITS  last good received byte.
REQ-009 Port rx_valid  output  1  rx_data holds an unacknowledged byte.
REQ-010 Port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 Port overrun  output  1  one-cycle pulse when an unacknowledged byte is overwritten.
REQ-012 Port busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer (rx_s); a third flop holds rx_s delayed by one cycle (rx_d) for edge detection.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 The bit timer count SHALL be held at 0 in IDLE, otherwise increment by 1 per cycle, wrap CLKS_PER_BIT-1 -> 0, and clear to 0 on every state change.
REQ-016 Timer width SHALL be $clog2(CLKS_PER_BIT).
REQ-017 half_tick SHALL equal (count == HALF_BIT-1); full_tick SHALL equal (count == CLKS_PER_BIT-1).
REQ-018 IDLE -> START only on a falling edge (rx_d=1, rx_s=0); a line held low (break) SHALL NOT start a frame.
REQ-019 START: on half_tick, rx_s=0 -> DATA with bit_idx=0; rx_s=1 -> IDLE (glitch reject, no outputs).
REQ-020 DATA: on each full_tick, shift rx_s into the shift register LSB-first and increment bit_idx; after DATA_BITS samples -> STOP.
REQ-021 STOP: on full_tick, rx_s=1 -> load rx_data from the shift register and set rx_valid; rx_s=0 -> pulse frame_err, leave rx_data and rx_valid unchanged; either case -> IDLE.
REQ-022 rx_valid SHALL clear on the cycle after rx_ack is sampled high while rx_valid=1; rx_ack while rx_valid=0 SHALL be ignored.
REQ-023 Good-frame load with rx_valid=1 and no rx_ack in the same cycle SHALL overwrite rx_data, keep rx_valid=1 and pulse overrun.
REQ-024 Good-frame load coinciding with rx_ack SHALL load new data, keep rx_valid=1, and SHALL NOT pulse overrun.
REQ-025 Latency: rx_valid SHALL rise 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT (+/-1) cycles after the rx falling edge.
REQ-026 frame_err and overrun SHALL never be high for more than one consecutive cycle per frame.

Reset
REQ-027 Reset SHALL act immediately, independent of clk, in any state including mid-frame.
REQ-028 Reset values: state IDLE, count 0, bit_idx 0, shift register 0, synchronizer and rx_d flops 1, rx_data 0, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-029 After reset release, the first falling edge of rx SHALL be received as a normal frame.

Structure
REQ-030 Shared package uart_rx_pkg SHALL hold the state enum and the default constants CLKS_PER_BIT, HALF_BIT and DATA_BITS.
REQ-031 The bit timer SHALL be one sub-module, rx_bit_timer (ports clk, reset, clear, half_tick, full_tick), instantiated once.
REQ-032 The FSM, synchronizer, shift register and output handshake SHALL reside in uart_rx_ctrl.

Verification (CLKS_PER_BIT=16, HALF_BIT=8)
REQ-033 Frame 0xA5 with a good stop bit, no ack -> rx_data=0xA5, rx_valid=1 held; ack -> rx_valid=0 on the next cycle; no frame_err or overrun.
REQ-034 rx low for 4 cycles, then high -> return to IDLE, busy low, no rx_valid or frame_err.
REQ-035 Frame 0x3C with stop bit 0 -> one frame_err pulse; rx_valid=0; rx_data=0x00; no new frame while rx stays low.
REQ-036 Back-to-back frames 0x11 then 0x22, no ack -> rx_data=0x22, rx_valid=1, exactly one overrun pulse; repeat with ack coinciding with the second load -> no overrun.
REQ-037 Reset asserted during DATA bit 4 -> all outputs at reset values within the same cycle; next frame 0x5A -> rx_data=0x5A, rx_valid=1.
